// File: rtl/life_pkg.sv
// Shared types and the Conway survival/birth rule for the life step scheduler.
package life_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

   localparam int GEN_W = 16;

   function automatic logic next_alive(input logic alive, input logic [3:0] cnt);
      return (cnt == 4'd3) | (alive & (cnt == 4'd2));
   endfunction

endpackage

// File: rtl/popcount_arith.sv
// Arithmetic population count of the 8 neighbour bits of one cell.
module popcount_arith (
   input  logic [7:0] bits_i,
   output logic [3:0] count_o
);

   always_comb begin
      count_o = '0;
      for (int i = 0; i < 8; i++) begin
         count_o = count_o + {3'b000, bits_i[i]};
      end
   end

endmodule

// File: rtl/life_step_scheduler.sv
// Advances a Conway board one cell per clock through a shared popcount unit,
// then commits the next board in a single cycle.
module life_step_scheduler
   import life_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int WRAP   = 0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      START,
   input  logic [7:0]                GENS,
   input  logic                      STOP,
   input  logic                      LOAD_EN,
   input  logic [$clog2(HEIGHT)-1:0] LOAD_ROW,
   input  logic [WIDTH-1:0]          LOAD_DATA,
   input  logic [$clog2(HEIGHT)-1:0] RD_ROW,
   output logic [WIDTH-1:0]          RD_DATA,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [GEN_W-1:0]          GEN_COUNT
);

   localparam int RW = $clog2(HEIGHT);
   localparam int CW = $clog2(WIDTH);

   state_e             state_q;
   logic [RW-1:0]      row_q;
   logic [CW-1:0]      col_q;
   logic [7:0]         rem_q;
   logic               stop_q;
   logic               busy_q;
   logic               done_q;
   logic [GEN_W-1:0]   gen_q;
   logic [WIDTH-1:0]   cur_q [HEIGHT];
   logic [WIDTH-1:0]   nxt_q [HEIGHT];

   logic [8:0]         win;
   logic [7:0]         nbrs;
   logic [3:0]         cnt;
   int                 rr;
   int                 cc;

   // 3x3 window around the scan cell; centre excluded, off-board reads dead unless wrapping
   always_comb begin
      win = '0;
      rr  = 0;
      cc  = 0;
      for (int dr = 0; dr < 3; dr++) begin
         for (int dc = 0; dc < 3; dc++) begin
            rr = int'(row_q) + dr - 1;
            cc = int'(col_q) + dc - 1;
            if (WRAP != 0) begin
               rr = (rr + HEIGHT) % HEIGHT;
               cc = (cc + WIDTH) % WIDTH;
            end
            if (rr >= 0 && rr < HEIGHT && cc >= 0 && cc < WIDTH) begin
               win[4'(dr * 3 + dc)] = cur_q[RW'(rr)][CW'(cc)];
            end
         end
      end
      win[4] = 1'b0;
   end

   assign nbrs = {win[8:5], win[3:0]};

   popcount_arith u_popcount (
      .bits_i  (nbrs),
      .count_o (cnt)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         rem_q   <= '0;
         stop_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gen_q   <= '0;
         for (int r = 0; r < HEIGHT; r++) begin
            cur_q[r] <= '0;
            nxt_q[r] <= '0;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (LOAD_EN && (int'(LOAD_ROW) < HEIGHT)) begin
                  cur_q[LOAD_ROW] <= LOAD_DATA;
               end
               if (START) begin
                  state_q <= SCAN;
                  row_q   <= '0;
                  col_q   <= '0;
                  rem_q   <= (GENS == 8'd0) ? 8'd1 : GENS;
                  stop_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            SCAN: begin
               nxt_q[row_q][col_q] <= next_alive(cur_q[row_q][col_q], cnt);
               if (STOP) begin
                  stop_q <= 1'b1;
               end
               if (col_q == CW'(WIDTH - 1)) begin
                  col_q <= '0;
                  if (row_q == RW'(HEIGHT - 1)) begin
                     row_q   <= '0;
                     state_q <= COMMIT;
                  end else begin
                     row_q <= row_q + 1'b1;
                  end
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
            COMMIT: begin
               for (int r = 0; r < HEIGHT; r++) begin
                  cur_q[r] <= nxt_q[r];
               end
               gen_q <= gen_q + 1'b1;
               rem_q <= rem_q - 1'b1;
               // a STOP arriving in the commit cycle itself still ends this run
               if (rem_q == 8'd1 || stop_q || STOP) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  stop_q  <= 1'b0;
               end else begin
                  state_q <= SCAN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign RD_DATA   = (int'(RD_ROW) < HEIGHT) ? cur_q[RD_ROW] : '0;
   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign GEN_COUNT = gen_q;

endmodule

// File: tb/tb_life_step_scheduler.sv
// Bench for life_step_scheduler: a bounded and a toroidal instance in lockstep
// against a whole-board Conway model.
module tb_life_step_scheduler;

   localparam int W   = 8;
   localparam int H   = 8;
   localparam int CYC = W * H + 1;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       START = 1'b0;
   logic       STOP = 1'b0;
   logic       LOAD_EN = 1'b0;
   logic [7:0] GENS = '0;
   logic [7:0] LOAD_DATA = '0;
   logic [2:0] LOAD_ROW = '0;
   logic [2:0] RD_ROW = '0;

   logic [7:0]  rd0, rd1;
   logic        busy0, busy1, done0, done1;
   logic [15:0] gc0, gc1;

   int          n_chk = 0;
   int          n_pass = 0;
   int          gen_model = 0;
   bit [7:0]    mb [2][8];

   always #5 CLK = ~CLK;

   life_step_scheduler #(.WIDTH(W), .HEIGHT(H), .WRAP(0)) u_dut0 (
      .CLK(CLK), .RST(RST), .START(START), .GENS(GENS), .STOP(STOP),
      .LOAD_EN(LOAD_EN), .LOAD_ROW(LOAD_ROW), .LOAD_DATA(LOAD_DATA),
      .RD_ROW(RD_ROW), .RD_DATA(rd0), .BUSY(busy0), .DONE(done0), .GEN_COUNT(gc0)
   );

   life_step_scheduler #(.WIDTH(W), .HEIGHT(H), .WRAP(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .START(START), .GENS(GENS), .STOP(STOP),
      .LOAD_EN(LOAD_EN), .LOAD_ROW(LOAD_ROW), .LOAD_DATA(LOAD_DATA),
      .RD_ROW(RD_ROW), .RD_DATA(rd1), .BUSY(busy1), .DONE(done1), .GEN_COUNT(gc1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One Conway generation over the whole model board
   function automatic void model_step(input bit w);
      bit [7:0] nb [8];
      int n, rr, cc;
      for (int r = 0; r < 8; r++) begin
         nb[3'(r)] = '0;
         for (int c = 0; c < 8; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     rr = r + dr;
                     cc = c + dc;
                     if (w) begin
                        rr = (rr + 8) % 8;
                        cc = (cc + 8) % 8;
                     end
                     if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                        n += int'(mb[w][3'(rr)][3'(cc)]);
                  end
               end
            end
            nb[3'(r)][3'(c)] = (n == 3) || (mb[w][3'(r)][3'(c)] && n == 2);
         end
      end
      for (int r = 0; r < 8; r++) mb[w][3'(r)] = nb[3'(r)];
   endfunction

   task automatic check_board();
      for (int r = 0; r < H; r++) begin
         RD_ROW = 3'(r);
         #1;
         check("rd_wrap0", 32'(rd0), 32'(mb[0][3'(r)]));
         check("rd_wrap1", 32'(rd1), 32'(mb[1][3'(r)]));
      end
   endtask

   task automatic check_row(input bit w, input int r, input logic [7:0] exp);
      RD_ROW = 3'(r);
      #1;
      if (w) check("golden_wrap1", 32'(rd1), 32'(exp));
      else   check("golden_wrap0", 32'(rd0), 32'(exp));
   endtask

   task automatic load_board(input logic [63:0] b);
      for (int r = 0; r < H; r++) begin
         @(negedge CLK);
         LOAD_EN   = 1'b1;
         LOAD_ROW  = 3'(r);
         LOAD_DATA = b[8*r +: 8];
         mb[0][3'(r)] = b[8*r +: 8];
         mb[1][3'(r)] = b[8*r +: 8];
      end
      @(negedge CLK);
      LOAD_EN = 1'b0;
   endtask

   // Launch a run and check BUSY/DONE every cycle until one cycle after DONE
   task automatic do_run(input int gens, input int stop_s, input bit junk,
                         input int ld_row, input logic [7:0] ld_data);
      int gm, geff;
      @(negedge CLK);
      START = 1'b1;
      GENS  = 8'(gens);
      if (ld_row >= 0) begin
         LOAD_EN   = 1'b1;
         LOAD_ROW  = 3'(ld_row);
         LOAD_DATA = ld_data;
         mb[0][3'(ld_row)] = ld_data;
         mb[1][3'(ld_row)] = ld_data;
      end
      @(negedge CLK);
      START   = 1'b0;
      LOAD_EN = 1'b0;
      gm   = (gens == 0) ? 1 : gens;
      geff = gm;
      if (stop_s >= 0 && (stop_s + CYC) / CYC < geff) geff = (stop_s + CYC) / CYC;
      for (int k = 0; k <= geff * CYC + 1; k++) begin
         check("busy_wrap0", 32'(busy0), 32'(k < geff * CYC));
         check("busy_wrap1", 32'(busy1), 32'(k < geff * CYC));
         check("done_wrap0", 32'(done0), 32'(k == geff * CYC));
         check("done_wrap1", 32'(done1), 32'(k == geff * CYC));
         STOP = (k == stop_s);
         if (junk && k == 10) begin
            START     = 1'b1;
            LOAD_EN   = 1'b1;
            LOAD_ROW  = 3'($urandom_range(0, 7));
            LOAD_DATA = 8'($urandom);
            GENS      = 8'd7;
         end else begin
            START   = 1'b0;
            LOAD_EN = 1'b0;
         end
         @(negedge CLK);
      end
      STOP = 1'b0;
      for (int g = 0; g < geff; g++) begin
         model_step(1'b0);
         model_step(1'b1);
      end
      gen_model += geff;
      check("gencount_wrap0", 32'(gc0), 32'(16'(gen_model)));
      check("gencount_wrap1", 32'(gc1), 32'(16'(gen_model)));
      check_board();
   endtask

   localparam logic [63:0] BLINKER = 64'h00000000_1C000000;
   localparam logic [63:0] GLIDER  = 64'hE0804000_00000000;

   initial begin
      for (int r = 0; r < 8; r++) begin
         mb[0][3'(r)] = '0;
         mb[1][3'(r)] = '0;
      end
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      check("rst_busy", 32'(busy0), 32'd0);
      check("rst_done", 32'(done0), 32'd0);
      check("rst_gencount", 32'(gc1), 32'd0);
      RST = 1'b0;
      check_board();

      load_board(BLINKER);
      do_run(1, -1, 1'b0, -1, 8'h00);
      check_row(1'b0, 1, 8'h00);
      check_row(1'b0, 2, 8'h08);
      check_row(1'b0, 3, 8'h08);
      check_row(1'b0, 4, 8'h08);

      load_board(BLINKER);
      do_run(2, -1, 1'b0, -1, 8'h00);
      check_row(1'b0, 3, 8'h1C);
      check_row(1'b1, 2, 8'h00);

      load_board(BLINKER);
      do_run(1, -1, 1'b1, -1, 8'h00);

      load_board(GLIDER);
      do_run(4, -1, 1'b0, -1, 8'h00);
      check_row(1'b1, 6, 8'h80);
      check_row(1'b1, 7, 8'h01);
      check_row(1'b1, 0, 8'hC1);
      check_row(1'b1, 5, 8'h00);

      load_board(BLINKER);
      do_run(10, 99, 1'b0, -1, 8'h00);

      load_board({$urandom, $urandom});
      do_run(0, -1, 1'b0, -1, 8'h00);

      for (int i = 0; i < 3; i++) begin
         load_board({$urandom, $urandom});
         do_run(int'($urandom_range(1, 3)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 150)) : -1,
                1'b0, int'($urandom_range(0, 7)), 8'($urandom));
      end

      // Abort a run with an asynchronous reset partway through the first scan
      load_board({$urandom, $urandom});
      @(negedge CLK);
      START = 1'b1;
      GENS  = 8'd3;
      @(negedge CLK);
      START = 1'b0;
      repeat (29) @(negedge CLK);
      #1 RST = 1'b1;
      #1;
      check("abort_busy0", 32'(busy0), 32'd0);
      check("abort_busy1", 32'(busy1), 32'd0);
      check("abort_gencount", 32'(gc0), 32'd0);
      @(negedge CLK);
      check("abort_done0", 32'(done0), 32'd0);
      check("abort_done1", 32'(done1), 32'd0);
      RST = 1'b0;
      for (int r = 0; r < 8; r++) begin
         mb[0][3'(r)] = '0;
         mb[1][3'(r)] = '0;
      end
      gen_model = 0;
      check_board();

      load_board(BLINKER);
      do_run(1, -1, 1'b0, -1, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
